matrix_framebuffer: RTL and testbench

Parametrised, double-buffered frame memory for the LED matrix pipeline, sitting between the HPS/Avalon-MM interconnect and the matrix scan controller. The host draws into a back bank through an Avalon slave with byte enables while the scanner reads the front bank through a dedicated read port. Bank swaps are deferred to the scanner's frame boundary so no tearing is visible. A hardware clear engine fills the back bank with a programmable value.

---
 rtl/matrix_fb_pkg.sv | 21 ++
 rtl/matrix_fb_ram.sv | 48 ++++
 rtl/matrix_framebuffer.sv | 163 ++++++++++++++++
 tb/tb_matrix_framebuffer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_fb_pkg.sv
// Shared definitions for the double-buffered LED matrix frame memory:
// CSR map, control/status bit positions and the control FSM states.
package matrix_fb_pkg;

    localparam logic [1:0] CSR_CTRL   = 2'd0;
    localparam logic [1:0] CSR_STATUS = 2'd1;
    localparam logic [1:0] CSR_CLEAR  = 2'd2;

    localparam int CTRL_SWAP_BIT  = 0;
    localparam int CTRL_CLEAR_BIT = 1;

    localparam int STAT_PENDING_BIT  = 0;
    localparam int STAT_CLEARING_BIT = 1;
    localparam int STAT_FRONT_BIT    = 2;

    typedef enum logic {
        FB_IDLE,
        FB_CLEAR
    } fb_state_t;

endpackage

// File: rtl/matrix_fb_ram.sv
// Two banks of DEPTH words: one byte-enabled write port plus independent
// registered read ports for the host and the scanner.
module matrix_fb_ram #(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1536,
    parameter string INIT_FILE = "",
    localparam int   ADDR_W    = $clog2(DEPTH),
    localparam int   BE_W      = DATA_W / 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic              wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [BE_W-1:0]   wr_be,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              host_bank,
    input  logic [ADDR_W-1:0] host_addr,
    output logic [DATA_W-1:0] host_data,
    input  logic              scan_bank,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic [DATA_W-1:0] scan_data
);

    localparam logic [ADDR_W:0] BANK_OFS = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [2*DEPTH];
    logic [ADDR_W:0]   wr_idx;
    logic [ADDR_W:0]   host_idx;
    logic [ADDR_W:0]   scan_idx;

    // Bank 1 sits directly above bank 0, so DEPTH need not be a power of two.
    function automatic logic [ADDR_W:0] flat_index(input logic bank, input logic [ADDR_W-1:0] addr);
        return {1'b0, addr} + (bank ? BANK_OFS : '0);
    endfunction

    assign wr_idx   = flat_index(wr_bank, wr_addr);
    assign host_idx = flat_index(host_bank, host_addr);
    assign scan_idx = flat_index(scan_bank, scan_addr);

    always_ff @(posedge clk) begin
        for (int i = 0; i < BE_W; i++) begin
            if (wr_en && wr_be[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
        host_data <= mem[host_idx];
        scan_data <= mem[scan_idx];
    end

endmodule

// File: rtl/matrix_framebuffer.sv
// Double-buffered frame memory: host draws into the back bank over Avalon-MM,
// scanner reads the front bank, swaps wait for the scanner's frame end.
module matrix_framebuffer
    import matrix_fb_pkg::*;
#(
    parameter int    DATA_W    = 32,
    parameter int    DEPTH     = 1536,
    parameter string INIT_FILE = "",
    localparam int   ADDR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W:0]     address,
    input  logic                chipselect,
    input  logic                read,
    input  logic                write,
    input  logic [DATA_W/8-1:0] byteenable,
    input  logic [DATA_W-1:0]   writedata,
    output logic [DATA_W-1:0]   readdata,
    output logic                waitrequest,
    input  logic [ADDR_W-1:0]   scan_addr,
    input  logic                scan_rd,
    output logic [DATA_W-1:0]   scan_data,
    output logic                scan_valid,
    input  logic                scan_frame_end,
    output logic                swap_pending
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    fb_state_t         state;
    logic [ADDR_W-1:0] clr_cnt;
    logic [DATA_W-1:0] clear_value;
    logic              front_bank;

    logic              csr_sel;
    logic [ADDR_W-1:0] pix_addr;
    logic              pix_in_range;
    logic              rd_accept;
    logic              wr_accept;
    logic              ctrl_wr;
    logic              swap_req;
    logic              clear_req;
    logic              do_swap;
    logic              clearing;

    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W/8-1:0] ram_be;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_host_data;
    logic [DATA_W-1:0] ram_scan_data;

    logic [DATA_W-1:0] csr_rdata;
    logic [DATA_W-1:0] csr_rd_q;
    logic              pix_rd_q;

    assign csr_sel      = address[ADDR_W];
    assign pix_addr     = address[ADDR_W-1:0];
    assign pix_in_range = (pix_addr <= LAST_ADDR);
    assign clearing     = (state == FB_CLEAR);

    assign waitrequest  = chipselect & (read | write) & ~csr_sel & clearing;
    assign rd_accept    = chipselect & read & ~waitrequest;
    assign wr_accept    = chipselect & write & ~waitrequest;

    assign ctrl_wr      = wr_accept & csr_sel & (address[1:0] == CSR_CTRL);
    assign swap_req     = ctrl_wr & writedata[CTRL_SWAP_BIT];
    assign clear_req    = ctrl_wr & writedata[CTRL_CLEAR_BIT];
    assign do_swap      = swap_pending & scan_frame_end & (state == FB_IDLE);

    // The clear engine owns the write port while running; host pixel traffic is stalled then.
    assign ram_we    = clearing | (wr_accept & ~csr_sel & pix_in_range);
    assign ram_waddr = clearing ? clr_cnt : pix_addr;
    assign ram_be    = clearing ? '1 : byteenable;
    assign ram_wdata = clearing ? clear_value : writedata;

    matrix_fb_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk       (clk),
        .wr_en     (ram_we),
        .wr_bank   (~front_bank),
        .wr_addr   (ram_waddr),
        .wr_be     (ram_be),
        .wr_data   (ram_wdata),
        .host_bank (~front_bank),
        .host_addr (pix_addr),
        .host_data (ram_host_data),
        .scan_bank (front_bank),
        .scan_addr (scan_addr),
        .scan_data (ram_scan_data)
    );

    always_comb begin
        csr_rdata = '0;
        case (address[1:0])
            CSR_STATUS: begin
                csr_rdata[STAT_PENDING_BIT]  = swap_pending;
                csr_rdata[STAT_CLEARING_BIT] = clearing;
                csr_rdata[STAT_FRONT_BIT]    = front_bank;
            end
            CSR_CLEAR: csr_rdata = clear_value;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FB_IDLE;
            clr_cnt <= '0;
        end else begin
            case (state)
                FB_IDLE: begin
                    if (clear_req) begin
                        state   <= FB_CLEAR;
                        clr_cnt <= '0;
                    end
                end
                FB_CLEAR: begin
                    if (clr_cnt == LAST_ADDR) state <= FB_IDLE;
                    else clr_cnt <= clr_cnt + 1'b1;
                end
                default: state <= FB_IDLE;
            endcase
        end
    end

    // A frame end that swaps wins over a same-cycle request, which is then a no-op.
    always_ff @(posedge clk) begin
        if (reset) begin
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
            clear_value  <= '0;
        end else begin
            if (do_swap) begin
                front_bank   <= ~front_bank;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
            if (wr_accept && csr_sel && address[1:0] == CSR_CLEAR) clear_value <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_rd_q   <= 1'b0;
            csr_rd_q   <= '0;
            scan_valid <= 1'b0;
        end else begin
            pix_rd_q   <= rd_accept & ~csr_sel & pix_in_range;
            csr_rd_q   <= (rd_accept & csr_sel) ? csr_rdata : '0;
            scan_valid <= scan_rd;
        end
    end

    assign readdata  = pix_rd_q ? ram_host_data : csr_rd_q;
    assign scan_data = scan_valid ? ram_scan_data : '0;

endmodule

// File: tb/tb_matrix_framebuffer.sv
// Directed + randomized bench for matrix_framebuffer against a bank-level
// reference model of the host/scan memory, swap flag and clear window.
module tb_matrix_framebuffer;

    localparam int DATA_W   = 32;
    localparam int DEPTH    = 1536;
    localparam int ADDR_W   = $clog2(DEPTH);
    localparam int BE_W     = DATA_W / 8;
    localparam int NO_CLEAR = -1000000;
    localparam int BOUND    = 4 * DEPTH;

    logic                clk = 1'b0;
    logic                reset;
    logic [ADDR_W:0]     address;
    logic                chipselect;
    logic                read;
    logic                write;
    logic [BE_W-1:0]     byteenable;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W-1:0]   readdata;
    logic                waitrequest;
    logic [ADDR_W-1:0]   scan_addr;
    logic                scan_rd;
    logic [DATA_W-1:0]   scan_data;
    logic                scan_valid;
    logic                scan_frame_end;
    logic                swap_pending;

    int n_vec = 0;
    int n_err = 0;
    int edge_no = 0;

    logic [DATA_W-1:0] m_mem [2*DEPTH];
    logic              m_front;
    logic              m_pending;
    logic [DATA_W-1:0] m_clear_value;
    int                clr_start = NO_CLEAR;

    matrix_framebuffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .address        (address),
        .chipselect     (chipselect),
        .read           (read),
        .write          (write),
        .byteenable     (byteenable),
        .writedata      (writedata),
        .readdata       (readdata),
        .waitrequest    (waitrequest),
        .scan_addr      (scan_addr),
        .scan_rd        (scan_rd),
        .scan_data      (scan_data),
        .scan_valid     (scan_valid),
        .scan_frame_end (scan_frame_end),
        .swap_pending   (swap_pending)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish (observed hang, expected completion)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Clear occupies the cycles between edge clr_start and edge clr_start+DEPTH.
    function automatic bit clearing_at(input int e);
        return (e > clr_start) && (e <= clr_start + DEPTH);
    endfunction

    function automatic int back_base();
        return m_front ? 0 : DEPTH;
    endfunction

    function automatic int front_base();
        return m_front ? DEPTH : 0;
    endfunction

    function automatic logic [DATA_W-1:0] status_model();
        logic [DATA_W-1:0] s;
        s    = '0;
        s[0] = m_pending;
        s[1] = clearing_at(edge_no + 1);
        s[2] = m_front;
        return s;
    endfunction

    function automatic logic [ADDR_W:0] pix(input int a);
        return {1'b0, ADDR_W'(a)};
    endfunction

    function automatic logic [ADDR_W:0] csr(input logic [1:0] idx);
        logic [ADDR_W:0] v;
        v         = '0;
        v[ADDR_W] = 1'b1;
        v[1:0]    = idx;
        return v;
    endfunction

    task automatic check_output(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // Applies the reference-model effect of the inputs present at the coming edge, then advances.
    task automatic tick();
        int  e;
        int  a;
        bit  busy;
        bit  swap_req;
        bit  clr_req;
        e        = edge_no + 1;
        swap_req = 1'b0;
        clr_req  = 1'b0;
        if (reset) begin
            m_front       = 1'b0;
            m_pending     = 1'b0;
            m_clear_value = '0;
            clr_start     = NO_CLEAR;
        end else begin
            busy = clearing_at(e);
            if (chipselect && write) begin
                if (address[ADDR_W]) begin
                    case (address[1:0])
                        2'd0: begin
                            swap_req = writedata[0];
                            clr_req  = writedata[1] && !busy;
                        end
                        2'd2: m_clear_value = writedata;
                        default: ;
                    endcase
                end else begin
                    a = int'(address[ADDR_W-1:0]);
                    if (!busy && a < DEPTH) begin
                        for (int b = 0; b < BE_W; b++)
                            if (byteenable[b]) m_mem[back_base() + a][b*8 +: 8] = writedata[b*8 +: 8];
                    end
                end
            end
            if (m_pending && scan_frame_end && !busy) begin
                m_front   = !m_front;
                m_pending = 1'b0;
            end else if (swap_req) begin
                m_pending = 1'b1;
            end
            if (clr_req) begin
                clr_start = e;
                for (int i = 0; i < DEPTH; i++) m_mem[back_base() + i] = m_clear_value;
            end
        end
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic apply_stimulus(input logic [ADDR_W:0] addr, input logic [DATA_W-1:0] data, input logic [BE_W-1:0] be);
        chipselect = 1'b1;
        write      = 1'b1;
        read       = 1'b0;
        address    = addr;
        writedata  = data;
        byteenable = be;
        tick();
        chipselect = 1'b0;
        write      = 1'b0;
    endtask

    task automatic host_check(input string tag, input int a);
        int                n;
        logic [DATA_W-1:0] exp;
        n          = 0;
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = pix(a);
        #1;
        while (waitrequest === 1'b1 && n < BOUND) begin
            tick();
            n++;
        end
        if (n >= BOUND) check_output({tag, "_wait_bound"}, 32'(n), 32'(BOUND - 1));
        exp = (a < DEPTH) ? m_mem[back_base() + a] : '0;
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        check_output(tag, readdata, exp);
    endtask

    task automatic csr_check(input string tag, input logic [1:0] idx, input logic [DATA_W-1:0] exp);
        chipselect = 1'b1;
        read       = 1'b1;
        write      = 1'b0;
        address    = csr(idx);
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        check_output(tag, readdata, exp);
    endtask

    task automatic scan_check(input string tag, input int a);
        logic [DATA_W-1:0] exp;
        scan_rd   = 1'b1;
        scan_addr = ADDR_W'(a);
        exp       = m_mem[front_base() + a];
        tick();
        scan_rd = 1'b0;
        check_output({tag, "_valid"}, 32'(scan_valid), 32'd1);
        check_output(tag, scan_data, exp);
    endtask

    task automatic pulse_frame_end();
        scan_frame_end = 1'b1;
        tick();
        scan_frame_end = 1'b0;
    endtask

    int                wr_addrs [40];
    int                cnt;
    int                k;
    int                a;
    logic [DATA_W-1:0] old_front;

    initial begin
        reset          = 1'b1;
        address        = '0;
        chipselect     = 1'b0;
        read           = 1'b0;
        write          = 1'b0;
        byteenable     = '0;
        writedata      = '0;
        scan_addr      = '0;
        scan_rd        = 1'b0;
        scan_frame_end = 1'b0;
        m_front        = 1'b0;
        m_pending      = 1'b0;
        m_clear_value  = '0;
        repeat (3) tick();

        check_output("rst_readdata", readdata, '0);
        check_output("rst_waitrequest", 32'(waitrequest), 32'd0);
        check_output("rst_scan_data", scan_data, '0);
        check_output("rst_scan_valid", 32'(scan_valid), 32'd0);
        check_output("rst_swap_pending", 32'(swap_pending), 32'd0);
        reset = 1'b0;
        tick();
        csr_check("rst_status", 2'd1, 32'd0);
        csr_check("rst_clear_value", 2'd2, 32'd0);

        // Prefill both banks with zero using the clear engine.
        apply_stimulus(csr(2'd0), 32'h2, '0);
        repeat (DEPTH) tick();
        csr_check("prefill_status_idle", 2'd1, status_model());
        apply_stimulus(csr(2'd0), 32'h1, '0);
        pulse_frame_end();
        apply_stimulus(csr(2'd0), 32'h2, '0);
        repeat (DEPTH) tick();
        apply_stimulus(csr(2'd0), 32'h1, '0);
        pulse_frame_end();
        csr_check("prefill_front0", 2'd1, 32'd0);

        apply_stimulus(pix(10), 32'hA5A5A5A5, 4'b0011);
        host_check("be_partial_model", 10);
        check_output("be_partial_const", readdata, 32'h0000A5A5);

        for (int i = 0; i < 40; i++) begin
            wr_addrs[i] = $urandom_range(0, DEPTH - 1);
            apply_stimulus(pix(wr_addrs[i]), $urandom, BE_W'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 40; i++) host_check("rand_rd", wr_addrs[i]);
        host_check("edge_last_word", DEPTH - 1);

        apply_stimulus(pix(5), 32'h11, 4'hF);
        apply_stimulus(csr(2'd0), 32'h1, '0);
        check_output("swap_pending_set", 32'(swap_pending), 32'd1);
        pulse_frame_end();
        check_output("swap_pending_clr", 32'(swap_pending), 32'd0);
        csr_check("status_after_swap", 2'd1, status_model());
        check_output("status_front_bit", 32'(readdata[2]), 32'd1);
        scan_check("scan_px5_model", 5);
        check_output("scan_px5_const", scan_data, 32'h11);
        for (int i = 0; i < 8; i++) scan_check("scan_rand", wr_addrs[i]);

        apply_stimulus(csr(2'd0), 32'h1, '0);
        repeat (1000) tick();
        check_output("deferred_pending", 32'(swap_pending), 32'd1);
        csr_check("deferred_status", 2'd1, status_model());
        apply_stimulus(csr(2'd0), 32'h1, '0);
        check_output("second_req_pending", 32'(swap_pending), 32'd1);
        pulse_frame_end();
        csr_check("one_toggle", 2'd1, status_model());
        pulse_frame_end();
        csr_check("no_extra_toggle", 2'd1, 32'd0);

        // Put the randomized data in front so the clear's untouched-front check means something.
        apply_stimulus(csr(2'd0), 32'h1, '0);
        pulse_frame_end();
        apply_stimulus(csr(2'd2), 32'h00FF00FF, '0);
        csr_check("clear_value_rb", 2'd2, 32'h00FF00FF);
        apply_stimulus(csr(2'd0), 32'h2, '0);
        chipselect = 1'b1;
        read       = 1'b1;
        address    = pix(7);
        #1;
        cnt = 0;
        while (waitrequest === 1'b1 && cnt < BOUND) begin
            tick();
            cnt++;
        end
        check_output("clear_stall_cycles", 32'(cnt), 32'(DEPTH));
        tick();
        chipselect = 1'b0;
        read       = 1'b0;
        check_output("stalled_read_data", readdata, 32'h00FF00FF);
        for (int i = 0; i < DEPTH; i++) host_check("clear_back", i);
        for (int i = 0; i < 40; i++) scan_check("clear_front_kept", wr_addrs[i]);

        apply_stimulus(csr(2'd2), $urandom, '0);
        apply_stimulus(csr(2'd0), 32'h2, '0);
        k = edge_no;
        apply_stimulus(csr(2'd0), 32'h1, '0);
        apply_stimulus(csr(2'd0), 32'h2, '0);
        csr_check("midclear_status", 2'd1, status_model());
        repeat (20) tick();
        pulse_frame_end();
        check_output("midclear_no_swap", 32'(swap_pending), 32'd1);
        csr_check("midclear_front", 2'd1, status_model());
        while (edge_no < k + DEPTH - 1) tick();
        chipselect = 1'b1;
        read       = 1'b1;
        address    = pix(3);
        #1;
        check_output("wait_last_clear", 32'(waitrequest), 32'd1);
        tick();
        check_output("wait_after_clear", 32'(waitrequest), 32'd0);
        chipselect = 1'b0;
        read       = 1'b0;
        pulse_frame_end();
        check_output("post_clear_swap", 32'(swap_pending), 32'd0);
        csr_check("post_clear_status", 2'd1, status_model());
        scan_check("new_front_0", 0);
        scan_check("new_front_last", DEPTH - 1);
        scan_check("new_front_rand", $urandom_range(0, DEPTH - 1));

        scan_frame_end = 1'b1;
        apply_stimulus(csr(2'd0), 32'h1, '0);
        scan_frame_end = 1'b0;
        check_output("same_cycle_pending", 32'(swap_pending), 32'd1);
        csr_check("same_cycle_front", 2'd1, status_model());
        pulse_frame_end();
        csr_check("same_cycle_then_swap", 2'd1, status_model());

        apply_stimulus(pix(0), 32'hCAFEF00D, 4'hF);
        old_front = m_mem[front_base()];
        apply_stimulus(pix(DEPTH), 32'hDEADBEEF, 4'hF);
        host_check("oor_read_model", DEPTH);
        check_output("oor_read_zero", readdata, '0);
        host_check("oor_back0_kept", 0);
        scan_check("oor_front0_kept", 0);
        check_output("oor_front0_const", scan_data, old_front);
        a = $urandom_range(DEPTH + 1, (1 << ADDR_W) - 1);
        apply_stimulus(pix(a), $urandom, 4'hF);
        host_check("oor_rand_read", a);
        host_check("oor_rand_back0", 0);

        apply_stimulus(csr(2'd3), 32'hFFFFFFFF, '0);
        csr_check("csr3_zero", 2'd3, 32'd0);
        csr_check("ctrl_reads_zero", 2'd0, 32'd0);
        csr_check("csr3_no_side_effect", 2'd1, status_model());
        csr_check("clear_value_kept", 2'd2, m_clear_value);

        apply_stimulus(csr(2'd0), 32'h3, '0);
        repeat (10) tick();
        chipselect = 1'b1;
        read       = 1'b1;
        address    = pix(2);
        reset      = 1'b1;
        #1;
        check_output("wait_before_reset", 32'(waitrequest), 32'd1);
        tick();
        check_output("wait_after_reset", 32'(waitrequest), 32'd0);
        check_output("pending_after_reset", 32'(swap_pending), 32'd0);
        check_output("readdata_after_reset", readdata, '0);
        chipselect = 1'b0;
        read       = 1'b0;
        reset      = 1'b0;
        tick();
        csr_check("status_after_reset", 2'd1, 32'd0);
        csr_check("clear_value_after_reset", 2'd2, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
